// File: rtl/req_capture4.sv
// Request capture front-end for the 4-to-2 priority encoder: synchronize, edge-capture, one-hot grant with valid/ack.
// Optional input debounce filter enabled by defining REQ_CAPTURE4_DEBOUNCE_EN.
module req_capture4 #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic       ack,
    input  logic       clr_ovf,
    output logic [3:0] grant,
    output logic       valid,
    output logic [3:0] pending,
    output logic       ovf
);

    typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [3:0] level;
    logic [3:0] hist_q, hist_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] grant_q, grant_d;
    logic       valid_q, valid_d;
    logic       ovf_q, ovf_d;
    state_t     state_q, state_d;
    logic [3:0] edge_w;
    logic [3:0] ack_clr;

    function automatic logic [3:0] pick_hi(input logic [3:0] p);
        if (p[3])      return 4'b1000;
        else if (p[2]) return 4'b0100;
        else if (p[1]) return 4'b0010;
        else if (p[0]) return 4'b0001;
        else           return 4'b0000;
    endfunction

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], req_in};
    end

`ifdef REQ_CAPTURE4_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [3:0][CW-1:0] cnt_q, cnt_d;
    logic [3:0]         filt_q, filt_d;

    // Filtered level flips only after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int b = 0; b < 4; b++) begin
            if (sync_q[SYNC_STAGES-1][b] == filt_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CW'(DB_CYCLES - 1)) begin
                filt_d[b] = ~filt_q[b];
                cnt_d[b]  = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    always_comb begin
        hist_d    = level;
        edge_w    = level & ~hist_q;
        ack_clr   = (state_q == PRESENT && ack) ? grant_q : 4'b0000;
        // A fresh edge wins over an ack on the same bit.
        pending_d = (pending_q & ~ack_clr) | edge_w;
        if (|(edge_w & pending_q & ~ack_clr)) ovf_d = 1'b1;
        else if (clr_ovf)                     ovf_d = 1'b0;
        else                                  ovf_d = ovf_q;

        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (pending_q != 4'b0000) begin
                    grant_d = pick_hi(pending_q);
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = 4'b0000;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            hist_q    <= '0;
            pending_q <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            state_q   <= IDLE;
        end else begin
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
        end
    end

    assign grant   = grant_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_req_capture4.sv
// Directed self-checking bench for req_capture4 (SYNC_STAGES=2, DB_CYCLES=4).
module tb_req_capture4;

`ifdef REQ_CAPTURE4_DEBOUNCE_EN
    localparam int LAT = 2 + 4 + 1;
`else
    localparam int LAT = 2 + 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_in;
    logic       ack;
    logic       clr_ovf;
    logic [3:0] grant;
    logic       valid;
    logic [3:0] pending;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    req_capture4 #(.SYNC_STAGES(2), .DB_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_in  (req_in),
        .ack     (ack),
        .clr_ovf (clr_ovf),
        .grant   (grant),
        .valid   (valid),
        .pending (pending),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_in = 4'b0; ack = 1'b0; clr_ovf = 1'b0;
        #12;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b want=0000", pending); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_single();
        req_in = 4'b0100;
        cyc(LAT - 1);
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL single_early got=%b want=0000", pending); end
        cyc(1);
        total++; if (pending !== 4'b0100) begin bad++; $display("FAIL single_pending got=%b want=0100", pending); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_valid_idle got=%b want=0", valid); end
        req_in = 4'b0000;
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b want=0100", grant); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", valid); end
        total++; if (pending !== 4'b0100) begin bad++; $display("FAIL idle_ack_ignored got=%b want=0100", pending); end
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        total++; if ({valid, grant, pending} !== 9'b0) begin bad++; $display("FAIL single_after_ack got=%b want=000000000", {valid, grant, pending}); end
        cyc(LAT + 2);
    endtask

    task automatic test_two_same_cycle();
        req_in = 4'b1001;
        cyc(LAT);
        total++; if (pending !== 4'b1001) begin bad++; $display("FAIL two_pending got=%b want=1001", pending); end
        req_in = 4'b0000;
        cyc(1);
        total++; if (grant !== 4'b1000) begin bad++; $display("FAIL two_first_grant got=%b want=1000", grant); end
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        total++; if ({valid, grant} !== 5'b0) begin bad++; $display("FAIL two_idle_gap got=%b want=00000", {valid, grant}); end
        total++; if (pending !== 4'b0001) begin bad++; $display("FAIL two_pending_mid got=%b want=0001", pending); end
        cyc(1);
        total++; if ({valid, grant} !== 5'b10001) begin bad++; $display("FAIL two_second_grant got=%b want=10001", {valid, grant}); end
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL two_pending_end got=%b want=0000", pending); end
        cyc(LAT + 2);
    endtask

    task automatic test_no_preempt();
        req_in = 4'b0001;
        cyc(LAT);
        req_in = 4'b0000;
        cyc(1);
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL np_grant0 got=%b want=0001", grant); end
        req_in = 4'b0100;
        cyc(LAT);
        total++; if (pending !== 4'b0101) begin bad++; $display("FAIL np_pending got=%b want=0101", pending); end
        req_in = 4'b0000;
        cyc(2);
        total++; if ({valid, grant} !== 5'b10001) begin bad++; $display("FAIL np_hold got=%b want=10001", {valid, grant}); end
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        total++; if (pending !== 4'b0100) begin bad++; $display("FAIL np_pending_mid got=%b want=0100", pending); end
        cyc(1);
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL np_grant2 got=%b want=0100", grant); end
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL np_pending_end got=%b want=0000", pending); end
        cyc(LAT + 2);
    endtask

    task automatic test_ovf();
        req_in = 4'b0010;
        cyc(LAT);
        req_in = 4'b0000;
        cyc(LAT + 2);
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL ovf_grant got=%b want=0010", grant); end
        req_in = 4'b0010;
        cyc(LAT);
        req_in = 4'b0000;
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", ovf); end
        total++; if (pending !== 4'b0010) begin bad++; $display("FAIL ovf_pending got=%b want=0010", pending); end
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", ovf); end
        cyc(LAT + 2);
        req_in = 4'b0010;
        cyc(LAT - 1);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        req_in = 4'b0000;
        total++; if (pending !== 4'b0010) begin bad++; $display("FAIL edge_ack_pending got=%b want=0010", pending); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL edge_ack_ovf got=%b want=0", ovf); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL edge_ack_valid got=%b want=0", valid); end
        cyc(1);
        total++; if ({valid, grant} !== 5'b10010) begin bad++; $display("FAIL edge_ack_regrant got=%b want=10010", {valid, grant}); end
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL ovf_pending_end got=%b want=0000", pending); end
        cyc(LAT + 2);
    endtask

    task automatic test_async_reset();
        req_in = 4'b1000;
        cyc(LAT);
        req_in = 4'b0000;
        cyc(1);
        total++; if ({valid, grant} !== 5'b11000) begin bad++; $display("FAIL ar_pre got=%b want=11000", {valid, grant}); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({valid, grant, pending} !== 9'b0) begin bad++; $display("FAIL ar_async_clear got=%b want=000000000", {valid, grant, pending}); end
        #2 rst_n = 1'b1;
        cyc(LAT + 3);
        total++; if ({valid, pending} !== 5'b0) begin bad++; $display("FAIL ar_no_regrant got=%b want=00000", {valid, pending}); end
    endtask

`ifdef REQ_CAPTURE4_DEBOUNCE_EN
    task automatic test_debounce();
        req_in = 4'b0001;
        cyc(3);
        req_in = 4'b0000;
        cyc(10);
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL db_short got=%b want=0000", pending); end
        req_in = 4'b0001;
        cyc(6);
        req_in = 4'b0000;
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL db_early got=%b want=0000", pending); end
        cyc(1);
        total++; if (pending !== 4'b0001) begin bad++; $display("FAIL db_long got=%b want=0001", pending); end
        cyc(1);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL db_ack got=%b want=0000", pending); end
        cyc(LAT + 2);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_two_same_cycle();
        test_no_preempt();
        test_ovf();
        test_async_reset();
`ifdef REQ_CAPTURE4_DEBOUNCE_EN
        test_debounce();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
